// File: rtl/candy_alu_arbiter.sv
// Round-robin arbiter sharing the single candy ALU between fetch/branch (0) and execute issue (1).
// Define CANDY_ALU_ARB_PERF_EN to add saturating grant/conflict performance counters.
module candy_alu_arbiter #(
  parameter int unsigned     DATA_W = 24,
  parameter int unsigned     OP_W   = 8,
  parameter logic [OP_W-1:0] OP_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_res_i
`ifdef CANDY_ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict
`endif
);

  localparam int unsigned PERF_W = 16;

  logic busy0, busy1;
  logic v1, v2;
  logic id1, id2;
  logic rr_last;
  logic elig0, elig1;
  logic grant;
  logic acc0, acc1;
  logic rsp0_hs, rsp1_hs;

  assign elig0 = req0_valid & ~busy0;
  assign elig1 = req1_valid & ~busy1;

  // A lone eligible requester wins; a contended cycle goes to the one that did not win last.
  always_comb begin
    grant = ~rr_last;
    if (elig0 && !elig1) begin
      grant = 1'b0;
    end else if (elig1 && !elig0) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = ~rst & ~busy0 & ~grant;
  assign req1_ready = ~rst & ~busy1 & grant;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign rsp0_hs    = rsp0_valid & rsp0_ready;
  assign rsp1_hs    = rsp1_valid & rsp1_ready;

  // Issue stage: ALU inputs come from registers; opcode falls back to NOP, operands hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_o <= OP_NOP;
      alu_a_o  <= '0;
      alu_b_o  <= '0;
      v1       <= 1'b0;
      id1      <= 1'b0;
      rr_last  <= 1'b1;
    end else if (acc1) begin
      alu_op_o <= req1_op;
      alu_a_o  <= req1_a;
      alu_b_o  <= req1_b;
      v1       <= 1'b1;
      id1      <= 1'b1;
      rr_last  <= 1'b1;
    end else if (acc0) begin
      alu_op_o <= req0_op;
      alu_a_o  <= req0_a;
      alu_b_o  <= req0_b;
      v1       <= 1'b1;
      id1      <= 1'b0;
      rr_last  <= 1'b0;
    end else begin
      alu_op_o <= OP_NOP;
      v1       <= 1'b0;
    end
  end

  // Follows the op while the ALU registers its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      id2 <= 1'b0;
    end else begin
      v2  <= v1;
      id2 <= id1;
    end
  end

  // Result slots; busy blocks a second op until the slot is drained, so capture and drain never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      busy0      <= 1'b0;
      busy1      <= 1'b0;
    end else begin
      if (v2 && !id2) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= alu_res_i;
      end else if (rsp0_hs) begin
        rsp0_valid <= 1'b0;
      end

      if (v2 && id2) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= alu_res_i;
      end else if (rsp1_hs) begin
        rsp1_valid <= 1'b0;
      end

      if (acc0) begin
        busy0 <= 1'b1;
      end else if (rsp0_hs) begin
        busy0 <= 1'b0;
      end

      if (acc1) begin
        busy1 <= 1'b1;
      end else if (rsp1_hs) begin
        busy1 <= 1'b0;
      end
    end
  end

`ifdef CANDY_ALU_ARB_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt, input logic en);
    if (en && (cnt != {PERF_W{1'b1}})) begin
      return cnt + PERF_W'(1);
    end
    return cnt;
  endfunction

  // Saturating accept and contention counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grant0   <= sat_inc(perf_grant0, acc0);
      perf_grant1   <= sat_inc(perf_grant1, acc1);
      perf_conflict <= sat_inc(perf_conflict, elig0 & elig1);
    end
  end
`endif

endmodule

// File: tb/tb_candy_alu_arbiter.sv
// Scoreboard bench for candy_alu_arbiter: random and directed requests against a round-robin reference.
// Build with CANDY_ALU_ARB_PERF_EN defined to also check the performance counters.
`timescale 1ns/1ps
module tb_candy_alu_arbiter;

  localparam logic [7:0] EXE_NOP = 8'h00;
  localparam logic [7:0] EXE_ADD = 8'h20;
  localparam logic [7:0] EXE_SUB = 8'h22;
  localparam logic [7:0] EXE_AND = 8'h24;
  localparam logic [7:0] EXE_OR  = 8'h25;
  localparam logic [7:0] EXE_XOR = 8'h26;
  localparam logic [7:0] EXE_MUL = 8'h18;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] a;
    logic [23:0] b;
  } op_t;

  typedef struct {
    logic [23:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op [2];
  logic [23:0] req_a [2];
  logic [23:0] req_b [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [23:0] rsp_data [2];
  logic [7:0]  alu_op;
  logic [23:0] alu_a;
  logic [23:0] alu_b;
  logic [23:0] alu_res;
`ifdef CANDY_ALU_ARB_PERF_EN
  logic [15:0] perf_g0, perf_g1, perf_conf;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Stimulus controls and reference-model state
  int          pv [2];
  int          pr [2];
  logic        rst_req;
  logic [1:0]  prev_acc;
  op_t         dq [2][$];
  exp_t        sb [2][$];
  logic [1:0]  mdl_busy;
  logic        mdl_last;
  logic        mdl_init;
  logic [7:0]  exp_alu_op;
  logic [23:0] exp_alu_a, exp_alu_b;
  logic [15:0] mdl_g0, mdl_g1, mdl_conf;

  logic [1:0]  mon_shown;
  logic [23:0] mon_held [2];
  logic        mon_was_rst;
  logic        mon_started;

  candy_alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_op    (req_op[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_op    (req_op[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp_data[0]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp_data[1]),
    .alu_op_o   (alu_op),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_res_i  (alu_res)
`ifdef CANDY_ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_g0),
    .perf_grant1   (perf_g1),
    .perf_conflict (perf_conf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] exe(input logic [7:0] op, input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    case (op)
      EXE_ADD: return a + b;
      EXE_SUB: return a - b;
      EXE_AND: return a & b;
      EXE_OR:  return a | b;
      EXE_XOR: return a ^ b;
      EXE_MUL: begin
        p = 48'(a) * 48'(b);
        return p[23:0];
      end
      default: return 24'h0;
    endcase
  endfunction

  // One-cycle registered ALU
  always @(posedge clk) alu_res <= exe(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] rand_operand();
    case ($urandom_range(7))
      0: return 24'hFFFFFF;
      1: return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [7:0] ops [6];
    ops  = '{EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_MUL};
    o.op = ops[$urandom_range(5)];
    o.a  = rand_operand();
    o.b  = rand_operand();
    return o;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  // Drive one cycle of stimulus, then check arbitration against the round-robin reference.
  task automatic step();
    logic [1:0] acc, elig, exp_acc;
    int w;
    @(negedge clk);
    #1;
    rst = rst_req;
    for (int n = 0; n < 2; n++) begin
      if (!req_valid[n] || prev_acc[n]) begin
        if (int'($urandom_range(99)) < pv[n]) begin
          op_t o;
          if (dq[n].size() != 0) o = dq[n].pop_front();
          else o = rand_op();
          req_valid[n] = 1'b1;
          req_op[n]    = o.op;
          req_a[n]     = o.a;
          req_b[n]     = o.b;
        end else begin
          req_valid[n] = 1'b0;
        end
      end
      rsp_ready[n] = (int'($urandom_range(99)) < pr[n]);
    end
    #3;
    acc = req_valid & req_ready;
    if (mdl_init) begin
      chk("alu_op", 64'(alu_op), 64'(exp_alu_op));
      chk("alu_a", 64'(alu_a), 64'(exp_alu_a));
      chk("alu_b", 64'(alu_b), 64'(exp_alu_b));
    end
    if (rst) begin
      chk("ready_in_rst", 64'(req_ready), 64'(0));
      mdl_busy   = 2'b00;
      mdl_last   = 1'b1;
      exp_alu_op = EXE_NOP;
      exp_alu_a  = '0;
      exp_alu_b  = '0;
      mdl_init   = 1'b1;
      mdl_g0     = '0;
      mdl_g1     = '0;
      mdl_conf   = '0;
    end else begin
      elig    = req_valid & ~mdl_busy;
      exp_acc = (elig == 2'b11) ? (mdl_last ? 2'b01 : 2'b10) : elig;
      chk("grant", 64'(acc), 64'(exp_acc));
      mdl_conf = sat16(mdl_conf, elig == 2'b11);
      mdl_g0   = sat16(mdl_g0, exp_acc[0]);
      mdl_g1   = sat16(mdl_g1, exp_acc[1]);
      if (exp_acc != 2'b00) begin
        w          = exp_acc[1] ? 1 : 0;
        exp_alu_op = req_op[w];
        exp_alu_a  = req_a[w];
        exp_alu_b  = req_b[w];
        mdl_busy[w] = 1'b1;
        mdl_last   = exp_acc[1];
        sb[w].push_back('{data: exe(req_op[w], req_a[w], req_b[w]), due: cyc + 3});
      end else begin
        exp_alu_op = EXE_NOP;
      end
      for (int n = 0; n < 2; n++) begin
        if (rsp_valid[n] && rsp_ready[n]) mdl_busy[n] = 1'b0;
      end
    end
    prev_acc = acc;
  endtask

  // Response monitor: pops the scoreboard when a result is due and checks hold/backpressure behaviour.
  initial begin
    mon_shown   = '0;
    mon_was_rst = 1'b0;
    mon_started = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (mon_was_rst) begin
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp0_data", 64'(rsp_data[0]), 64'(0));
        chk("rst_rsp1_data", 64'(rsp_data[1]), 64'(0));
        chk("rst_alu_op", 64'(alu_op), 64'(EXE_NOP));
        chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'(0));
      end
      if (rst) begin
        for (int n = 0; n < 2; n++) begin
          sb[n].delete();
          mon_held[n] = '0;
        end
        mon_shown   = '0;
        mon_started = 1'b1;
      end else if (mon_started) begin
        for (int n = 0; n < 2; n++) begin
          logic new_rsp;
          logic has_due;
          exp_t e;
          if (mon_shown[n]) begin
            chk($sformatf("rsp%0d_valid_hold", n), 64'(rsp_valid[n]), 64'(1));
            chk($sformatf("rsp%0d_data_hold", n), 64'(rsp_data[n]), 64'(mon_held[n]));
          end else if (!rsp_valid[n]) begin
            chk($sformatf("rsp%0d_data_idle", n), 64'(rsp_data[n]), 64'(mon_held[n]));
          end
          new_rsp = rsp_valid[n] & ~mon_shown[n];
          has_due = (sb[n].size() != 0) && (sb[n][0].due <= cyc);
          if (new_rsp || has_due) begin
            chk($sformatf("rsp%0d_timing", n), 64'({new_rsp, has_due}), 64'(2'b11));
            if (has_due) begin
              e = sb[n].pop_front();
              if (new_rsp) begin
                chk($sformatf("rsp%0d_data", n), 64'(rsp_data[n]), 64'(e.data));
                mon_held[n] = e.data;
              end
            end
          end
          mon_shown[n] = rsp_valid[n] & ~rsp_ready[n];
        end
      end
      mon_was_rst = rst;
    end
  end

  initial begin
    logic got;
    req_valid = '0;
    rsp_ready = '0;
    for (int n = 0; n < 2; n++) begin
      req_op[n] = '0;
      req_a[n]  = '0;
      req_b[n]  = '0;
      pv[n]     = 0;
      pr[n]     = 100;
    end
    rst_req  = 1'b1;
    prev_acc = '0;
    mdl_init = 1'b0;
    mdl_busy = '0;
    mdl_last = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;

    // Lone ADD from requester 0
    dq[0].push_back('{EXE_ADD, 24'h000005, 24'h000003});
    pv[0] = 100;
    repeat (6) step();

    // Contended AND/OR stream with both requesters always valid
    for (int i = 0; i < 4; i++) begin
      dq[0].push_back('{EXE_AND, 24'($urandom), 24'($urandom)});
      dq[1].push_back('{EXE_OR, 24'($urandom), 24'($urandom)});
    end
    pv[1] = 100;
    repeat (16) step();

    // Requester 0 backpressured while requester 1 runs SUBs
    for (int i = 0; i < 4; i++) dq[1].push_back('{EXE_SUB, 24'h000010, 24'h000001});
    pr[0] = 0;
    repeat (14) step();
    pr[0] = 100;
    repeat (4) step();
    pv[0] = 0;
    pv[1] = 0;
    repeat (10) step();

    // Reset the cycle after a MUL is accepted
    dq[0].push_back('{EXE_MUL, 24'h000100, 24'h000100});
    pv[0] = 100;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = prev_acc[0];
    end
    chk("mul_accept_before_rst", 64'(got), 64'(1));
    pv[0]   = 0;
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0;
    repeat (3) step();

    // Service after reset, then MUL truncation
    dq[0].push_back('{EXE_ADD, 24'h000100, 24'h000100});
    dq[0].push_back('{EXE_MUL, 24'h001000, 24'h001000});
    dq[1].push_back('{EXE_MUL, 24'hFFFFFF, 24'hFFFFFF});
    pv[0] = 100;
    pv[1] = 100;
    repeat (12) step();

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        pv[0] = int'($urandom_range(30, 100));
        pv[1] = int'($urandom_range(30, 100));
        pr[0] = int'($urandom_range(10, 100));
        pr[1] = int'($urandom_range(10, 100));
      end
      step();
    end

    pv[0] = 0;
    pv[1] = 0;
    pr[0] = 100;
    pr[1] = 100;
    repeat (12) step();
    chk("sb0_drained", 64'(sb[0].size()), 64'(0));
    chk("sb1_drained", 64'(sb[1].size()), 64'(0));
`ifdef CANDY_ALU_ARB_PERF_EN
    chk("perf_grant0", 64'(perf_g0), 64'(mdl_g0));
    chk("perf_grant1", 64'(perf_g1), 64'(mdl_g1));
    chk("perf_conflict", 64'(perf_conf), 64'(mdl_conf));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
